// File: rtl/cache_pkg.sv
// Shared types for the cache request decoder: FIFO entry layout, address
// split defaults and the decoder FSM state encoding.
package cache_pkg;

  localparam int ADDR_W    = 64;
  localparam int ID_W      = 16;
  localparam int OFF_W_DEF = 6;
  localparam int SET_W_DEF = 16;
  localparam int ENTRY_W   = 1 + ID_W + ADDR_W;

  typedef struct packed {
    logic              is_write;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } cache_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/cache_credit_cnt.sv
// Outstanding-request counter: +1 per issued request, -1 per completion.
// A completion with nothing outstanding is a protocol error and is sticky.
module cache_credit_cnt #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  // inc is only ever raised below MAX_OUT by the issuing side, so no
  // overflow guard is needed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count == '0) begin
        err <= 1'b1;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_req_decoder.sv
// Pops request entries from an upstream FIFO, splits the address into
// set/tag and presents them downstream, gated by an outstanding-credit limit.
module cache_req_decoder
  import cache_pkg::*;
#(
  parameter int  OFF_W   = OFF_W_DEF,
  parameter int  SET_W   = SET_W_DEF,
  parameter int  MAX_OUT = 4,
  localparam int TAG_W   = ADDR_W - OFF_W - SET_W,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               aempty_i,
  output logic               rden_o,
  input  logic [ENTRY_W-1:0] data_i,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic               req_wr_o,
  output logic [ID_W-1:0]    req_id_o,
  output logic [ADDR_W-1:0]  req_addr_o,
  output logic [SET_W-1:0]   req_set_o,
  output logic [TAG_W-1:0]   req_tag_o,
  input  logic               done_i,
  output logic [CNT_W-1:0]   outstanding_o,
  output logic               err_o,
  output state_e             dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid_o and
  // req_ready_i are both high; once raised, valid and all req_* fields hold
  // until that edge. ready without valid has no effect.

  state_e       state;
  state_e       state_nxt;
  cache_entry_t entry;
  logic         gate_open;
  logic         accept;

  assign entry     = cache_entry_t'(data_i);
  assign gate_open = outstanding_o < CNT_W'(MAX_OUT);
  assign accept    = req_valid_o && req_ready_i;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pop is suppressed during reset so no entry is taken only to be dropped.
  always_comb begin
    state_nxt   = state;
    rden_o      = 1'b0;
    req_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (!aempty_i && gate_open && !rst) begin
          rden_o    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = ISSUE;
      ISSUE: begin
        req_valid_o = 1'b1;
        if (req_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The FIFO presents the popped entry during FETCH; capture it there.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_wr_o   <= 1'b0;
      req_id_o   <= '0;
      req_addr_o <= '0;
      req_set_o  <= '0;
      req_tag_o  <= '0;
    end else if (state == FETCH) begin
      req_wr_o   <= entry.is_write;
      req_id_o   <= entry.id;
      req_addr_o <= entry.addr;
      req_set_o  <= entry.addr[OFF_W+SET_W-1:OFF_W];
      req_tag_o  <= entry.addr[ADDR_W-1:OFF_W+SET_W];
    end
  end

  cache_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .dec   (done_i),
    .count (outstanding_o),
    .err   (err_o)
  );

endmodule

// File: tb/tb_cache_req_decoder.sv
// Bench for cache_req_decoder: FIFO model + driver, a reference model of
// pop/issue/credit behaviour, and a scoreboard monitor on the request port.
module tb_cache_req_decoder;
  import cache_pkg::*;

  localparam int OFF_W   = 6;
  localparam int SET_W   = 16;
  localparam int MAX_OUT = 4;
  localparam int TAG_W   = 64 - OFF_W - SET_W;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam int EXP_W   = 81 + SET_W + TAG_W;

  // clock / reset / DUT signals
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aempty_i = 1'b1;
  logic              rden_o;
  logic [80:0]       data_i = '0;
  logic              req_valid_o;
  logic              req_ready_i = 1'b0;
  logic              req_wr_o;
  logic [15:0]       req_id_o;
  logic [63:0]       req_addr_o;
  logic [SET_W-1:0]  req_set_o;
  logic [TAG_W-1:0]  req_tag_o;
  logic              done_i = 1'b0;
  logic [CNT_W-1:0]  outstanding_o;
  logic              err_o;
  state_e            dbg_state;

  always #5 clk = ~clk;

  cache_req_decoder #(.OFF_W(OFF_W), .SET_W(SET_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .aempty_i(aempty_i), .rden_o(rden_o), .data_i(data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_wr_o(req_wr_o),
    .req_id_o(req_id_o), .req_addr_o(req_addr_o), .req_set_o(req_set_o),
    .req_tag_o(req_tag_o), .done_i(done_i), .outstanding_o(outstanding_o),
    .err_o(err_o), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // reference model: address split by plain arithmetic
  function automatic logic [EXP_W-1:0] model_exp(input logic [80:0] e);
    logic [63:0] a;
    logic [63:0] s;
    logic [63:0] t;
    a = e[63:0];
    s = (a >> OFF_W) % (64'd1 << SET_W);
    t = a >> (OFF_W + SET_W);
    return {e, s[SET_W-1:0], t[TAG_W-1:0]};
  endfunction

  // FIFO model and driver state
  logic [80:0]      fifo_q[$];
  logic [80:0]      fetch_data;
  bit               fetch_pending = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               pops = 0;
  int               pop_cyc = 0;

  task automatic push_entry(input logic wr, input logic [15:0] id, input logic [63:0] addr);
    fifo_q.push_back({wr, id, addr});
  endtask

  task automatic tick(input logic rdy, input logic dn, input logic dnv = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    rst = r;
    if (r) fetch_pending = 0;
    if (fetch_pending) begin
      data_i        = fetch_data;
      fetch_pending = 0;
    end else begin
      data_i = 81'({$urandom(), $urandom(), $urandom()});
    end
    aempty_i    = rst || (fifo_q.size() == 0);
    req_ready_i = rdy;
    done_i      = dn || (dnv && req_valid_o);
    #1;
    if (rden_o === 1'b1 && fifo_q.size() > 0) begin
      fetch_data    = fifo_q.pop_front();
      fetch_pending = 1;
      exp_q.push_back(model_exp(fetch_data));
      pops++;
      pop_cyc = cyc;
    end
    #2;
  endtask

  // monitor / scoreboard
  bit               inflight = 0;
  int               age = 0;
  int               cnt_m = 0;
  bit               err_m = 0;
  logic             exp_rden, exp_valid, acc_m;
  logic [EXP_W-1:0] ex;
  int               accs = 0;
  int               stalls = 0;
  int               rise_cyc = 0;
  logic             prev_valid = 1'b0;
  bit               id5_accepted = 0;
  logic             acc_wr;
  logic [15:0]      acc_id;
  logic [SET_W-1:0] acc_set;
  logic [TAG_W-1:0] acc_tag;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      inflight   = 0;
      age        = 0;
      cnt_m      = 0;
      err_m      = 0;
      prev_valid = 1'b0;
      exp_q.delete();
    end else begin
      exp_rden  = !inflight && !aempty_i && (cnt_m < MAX_OUT);
      exp_valid = inflight && (age >= 2);
      check("rden", rden_o, exp_rden);
      check("valid", req_valid_o, exp_valid);
      check("outstanding", outstanding_o, cnt_m);
      check("err", err_o, err_m);
      if (req_valid_o && !prev_valid) rise_cyc = cyc;
      prev_valid = req_valid_o;
      if (req_valid_o && !req_ready_i) stalls++;
      if (exp_valid && exp_q.size() > 0) begin
        ex = exp_q[0];
        check("req_wr", req_wr_o, ex[EXP_W-1]);
        check("req_id", req_id_o, ex[EXP_W-2 -: 16]);
        check("req_addr", req_addr_o, ex[SET_W+TAG_W +: 64]);
        check("req_set", req_set_o, ex[TAG_W +: SET_W]);
        check("req_tag", req_tag_o, ex[TAG_W-1:0]);
      end
      acc_m = exp_valid && req_ready_i;
      if (acc_m) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        accs++;
        acc_wr  = req_wr_o;
        acc_id  = req_id_o;
        acc_set = req_set_o;
        acc_tag = req_tag_o;
        if (req_id_o == 16'd5) id5_accepted = 1;
      end
      if (inflight) begin
        if (acc_m) inflight = 0;
        else age++;
      end else if (exp_rden) begin
        inflight = 1;
        age      = 1;
      end
      if (acc_m && !done_i) cnt_m++;
      else if (done_i && !acc_m) begin
        if (cnt_m == 0) err_m = 1;
        else cnt_m--;
      end
    end
  end

  int a0, p0, s0;

  task automatic run_until_accs(input int target, input int budget, input logic dnv);
    for (int i = 0; i < budget && accs < target; i++) tick(1'b1, 1'b0, dnv);
    check("accept_wait", accs, target);
  endtask

  initial begin
    // reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("rst_valid", req_valid_o, 0);
    check("rst_rden", rden_o, 0);
    check("rst_wr", req_wr_o, 0);
    check("rst_id", req_id_o, 0);
    check("rst_addr", req_addr_o, 0);
    check("rst_set", req_set_o, 0);
    check("rst_tag", req_tag_o, 0);
    check("rst_cnt", outstanding_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state, IDLE);

    // single request, ready high
    push_entry(1'b0, 16'h0007, 64'heeeeeeeeeeeeeeee);
    a0 = accs; p0 = pops;
    run_until_accs(a0 + 1, 10, 1'b0);
    tick(1'b0, 1'b0);
    check("t1_latency", rise_cyc - pop_cyc, 2);
    check("t1_pops", pops - p0, 1);
    check("t1_id", acc_id, 16'h0007);
    check("t1_wr", acc_wr, 0);
    check("t1_set", acc_set, 16'hbbbb);
    check("t1_tag", acc_tag, 42'h3bbbbbbbbbb);
    check("t1_cnt", outstanding_o, 1);

    // backpressure for 5 valid cycles
    push_entry(1'b0, 16'h0007, 64'heeeeeeeeeeeeeeee);
    a0 = accs; p0 = pops; s0 = stalls;
    repeat (7) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("t2_accs", accs - a0, 1);
    check("t2_pops", pops - p0, 1);
    check("t2_stalls", stalls - s0, 5);
    check("t2_cnt", outstanding_o, 2);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("t2_drain", outstanding_o, 0);

    // credit limit with 6 queued entries
    for (int i = 0; i < 6; i++) push_entry(1'($urandom_range(0, 1)), 16'($urandom()), {$urandom(), $urandom()});
    a0 = accs; p0 = pops;
    repeat (30) tick(1'b1, 1'b0);
    check("t3_pops", pops - p0, 4);
    check("t3_accs", accs - a0, 4);
    check("t3_cnt", outstanding_o, 4);
    check("t3_fifo", fifo_q.size(), 2);
    check("t3_rden_held", rden_o, 0);
    tick(1'b1, 1'b1);
    check("t3_gate_same_cycle", pops - p0, 4);
    tick(1'b1, 1'b0);
    check("t3_fifth_pop", pops - p0, 5);
    fifo_q.delete();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("t3_rst_cnt", outstanding_o, 0);

    // done coincident with accept at count 2
    for (int i = 0; i < 3; i++) push_entry(1'b1, 16'($urandom()), {$urandom(), $urandom()});
    a0 = accs;
    run_until_accs(a0 + 2, 20, 1'b0);
    run_until_accs(a0 + 3, 10, 1'b1);
    tick(1'b0, 1'b0);
    check("t4_cnt", outstanding_o, 2);
    check("t4_err", err_o, 0);

    // underflow sets sticky error
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("t5_cnt", outstanding_o, 0);
    check("t5_err", err_o, 1);
    repeat (5) tick(1'b0, 1'b0);
    check("t5_err_sticky", err_o, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("t5_err_clr", err_o, 0);

    // reset while issuing id 5
    push_entry(1'b1, 16'd5, {$urandom(), $urandom()});
    a0 = accs;
    repeat (3) tick(1'b0, 1'b0);
    check("t6_valid_before", req_valid_o, 1);
    check("t6_id_before", req_id_o, 5);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0);
    check("t6_valid", req_valid_o, 0);
    check("t6_cnt", outstanding_o, 0);
    check("t6_state", dbg_state, IDLE);
    check("t6_no_accept", accs - a0, 0);
    check("t6_id5", id5_accepted, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        push_entry(1'($urandom_range(0, 1)), 16'($urandom()), {$urandom(), $urandom()});
      tick(1'($urandom_range(0, 1)), 1'((cnt_m > 0) && ($urandom_range(0, 3) == 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
